// File: rtl/aes_pkg.sv
// Purpose: shared AES constants, FSM encoding and GF(2^8) helpers for the inverse cipher.
// Latency: n/a (types, parameters and pure combinational functions only).
// Backpressure: n/a.
// Ports: none. AES256_EN selects whether NR_256 is reachable in the top module.
package aes_pkg;

  localparam int BLOCK_LENGTH = 128;
  localparam int NR_128       = 10;
  localparam int NR_256       = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  typedef logic [3:0] round_idx_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map (rotations 1,3,6 plus 0x05), then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(s);
  endfunction

  // One InvMixColumns column; row 0 sits in the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Purpose: one AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller registers the result.
// Ports: state/key (128-bit) in, last_round bypasses InvMixColumns, result (128-bit) out.
// Byte n of the block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3 (row = n % 4).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_LENGTH-1:0] state,
  input  logic [BLOCK_LENGTH-1:0] key,
  input  logic                    last_round,
  output logic [BLOCK_LENGTH-1:0] result
);

  logic [BLOCK_LENGTH-1:0] sr;  // after inv_shift_rows
  logic [BLOCK_LENGTH-1:0] sb;  // after inv_sub_bytes
  logic [BLOCK_LENGTH-1:0] ak;  // after key_add
  logic [BLOCK_LENGTH-1:0] mc;  // after inv_mix_columns

  // inv_shift_rows: row r rotates right by r, so (r,c) takes the byte from column (c-r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  // inv_sub_bytes
  always_comb begin
    sb = '0;
    for (int n = 0; n < 16; n++) begin
      sb[127-8*n -: 8] = inv_sbox(sr[127-8*n -: 8]);
    end
  end

  // key_add
  assign ak = sb ^ key;

  // inv_mix_columns
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    end
  end

  assign result = last_round ? ak : mc;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Purpose: iterative AES inverse cipher, one round per clock, round keys fetched via key_idx.
// Latency: accept at edge t -> out_valid after edge t+Nr; next accept no sooner than Nr+2 cycles.
// Backpressure: OUT/out_valid hold in DONE until out_ready; in_ready is high only in IDLE.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/IN, key_idx/round_key (same-cycle
//        key store), out_valid/out_ready/OUT (registered), busy (ROUND or FINAL).
// Build option: define AES256_EN to add key_len (0=AES-128, 1=AES-256), sampled at accept.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  output logic [3:0]              key_idx,
  input  logic [BLOCK_LENGTH-1:0] round_key,
`ifdef AES256_EN
  input  logic                    key_len,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    busy
);

  fsm_state_t              st, st_nxt;
  round_idx_t              ctr;
  round_idx_t              nr_sel;
  logic [BLOCK_LENGTH-1:0] blk;
  logic [BLOCK_LENGTH-1:0] out_q;
  logic                    out_valid_q;
  logic [BLOCK_LENGTH-1:0] rnd_out;
  logic                    last_round;

  // Round count is only needed in IDLE (first key index and counter load); afterwards the
  // counter alone carries the schedule, so later key_len changes cannot disturb a block.
`ifdef AES256_EN
  assign nr_sel = key_len ? 4'(NR_256) : 4'(NR_128);
`else
  assign nr_sel = 4'(NR_128);
`endif

  assign last_round = (st == FINAL);

  aes_inv_round u_round (
    .state      (blk),
    .key        (round_key),
    .last_round (last_round),
    .result     (rnd_out)
  );

  always_comb begin
    st_nxt   = st;
    key_idx  = 4'd0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (st)
      IDLE: begin
        key_idx  = nr_sel;
        in_ready = 1'b1;
        if (in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        key_idx = ctr;
        busy    = 1'b1;
        if (ctr == 4'd1) st_nxt = FINAL;
      end
      FINAL: begin
        busy   = 1'b1;
        st_nxt = DONE;
      end
      DONE: begin
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      ctr         <= '0;
      blk         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st <= st_nxt;
      case (st)
        IDLE: begin
          if (in_valid) begin
            blk <= IN ^ round_key;
            ctr <= nr_sel - 4'd1;
          end
        end
        ROUND: begin
          blk <= rnd_out;
          ctr <= ctr - 4'd1;
        end
        FINAL: begin
          out_q       <= rnd_out;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign OUT       = out_q;
  assign out_valid = out_valid_q;

endmodule
